mem_io_cycle_fsm: RTL and testbench
===================================

Name: mem_io_cycle_fsm

Overview:
- Bus-cycle engine for the non-fetch Z80 machine cycles: memory read, memory write, I/O read and I/O write.
- Sits beside the opcode-fetch engine, downstream of the decoder. The decoder dispatches one cycle per start pulse and waits for done; the bus mux in control_logic forwards this block's strobes while the decoder grants it the bus.
- Generates T1/T2/TW/T3 timing, honours WAIT_L, and returns read data latched from the data bus.

Parameters:
- IO_AUTO_WAIT, 1, number of automatic TW states inserted in every I/O cycle (0-3).
- WAIT_TIMEOUT, 255, maximum consecutive externally requested TW cycles before the cycle is aborted; width is $clog2(WAIT_TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request from decoder; accepted only when busy=0
- kind  in  2  cycle type, sampled with start: MEM_RD=0, MEM_WR=1, IO_RD=2, IO_WR=3
- addr_in  in  16  cycle address, sampled with start
- wdata_in  in  8  write data, sampled with start
- data_in  in  8  data bus input
- WAIT_L  in  1  external wait request, active low
- busy  out  1  high from the cycle after an accepted start through T3
- done  out  1  one-cycle pulse in T3
- timeout  out  1  one-cycle pulse in place of done on abort
- rdata  out  8  read data, valid from the done pulse until the next accepted read
- addr_out  out  16  latched address in T1..T3, otherwise 0
- data_out  out  8  latched write data, otherwise 0
- data_oe  out  1  data_out drive enable
- MREQ_L, IORQ_L, RD_L, WR_L  out  1 each  bus strobes, active low

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset state: state=IDLE; busy=0; done=0; timeout=0; rdata=0; addr_out=0; data_out=0; data_oe=0; all strobes=1.
- Reset is dominant, including mid-cycle: the next edge forces IDLE and deasserts all strobes immediately, with no done and no timeout.
- States: IDLE, T1, T2, TW, T3.
  - IDLE -> T1 when start=1; kind, addr_in and wdata_in are latched on that edge. start is ignored in every other state.
  - T1 -> T2.
  - T2 -> TW if the cycle is I/O and IO_AUTO_WAIT>0, or if WAIT_L=0. Otherwise T2 -> T3.
  - TW: stays in TW while the auto-wait count remains or WAIT_L=0; otherwise -> T3. Auto-waits are counted first; WAIT_L is sampled in T2 and in every TW.
  - T3 -> IDLE.
- Wait counter: counts only consecutive WAIT_L=0 samples. When it reaches WAIT_TIMEOUT while WAIT_L is still 0, the next state is IDLE, timeout pulses for one cycle, strobes deassert and rdata is unchanged.
- All outputs are Moore outputs (decoded from state and latched kind); no combinational path from start to the bus.
- Strobe timing:
  - MEM_RD: MREQ_L=0 and RD_L=0 in T1, T2, TW, T3.
  - MEM_WR: MREQ_L=0 in T1..T3; WR_L=0 in T2..T3; data_oe=1 in T1..T3.
  - IO_RD: IORQ_L=0 and RD_L=0 in T2, TW, T3.
  - IO_WR: IORQ_L=0 and WR_L=0 in T2, TW, T3; data_oe=1 in T1..T3.
- Read capture: rdata is loaded from data_in on the edge that enters T3. done is high in T3, and rdata already holds the new value in that cycle.
- Latency with no waits:
  - Memory cycle: start at cycle 0 -> T1 at 1, T2 at 2, T3/done at 3.
  - I/O cycle: done at 3+IO_AUTO_WAIT+n, where n is the number of external waits.
- Back-to-back: start may be asserted in the done cycle. It is ignored because busy=1; the decoder re-issues it in IDLE, which gives a minimum of one IDLE cycle between cycles.
- Simultaneous start and rst: reset wins and start is dropped.

Decomposition:
- Shared package z80_pkg:
  - cycle_kind_t enum (MEM_RD, MEM_WR, IO_RD, IO_WR)
  - bus_state_t enum (IDLE, T1, T2, TW, T3)
  - localparam for the default WAIT_TIMEOUT
- One sub-module, wait_ctr: loadable down-counter for auto-waits plus an up-counter for external waits. Inputs are a clear, an auto-load and WAIT_L; outputs are a waits-pending flag and an expired flag.

Test Plan:
- MEM_RD, addr_in=16'h1234, data_in=8'hA5, WAIT_L=1 -> MREQ_L/RD_L low for cycles 1-3; addr_out=1234; done at cycle 3; rdata=A5.
- MEM_WR, addr_in=16'h8000, wdata_in=8'h3C -> data_oe=1 with data_out=3C in cycles 1-3; WR_L low only in cycles 2-3; done at 3; rdata unchanged.
- IO_RD, addr_in=16'h00FE, IO_AUTO_WAIT=1, WAIT_L held low 2 cycles from T2 -> IORQ_L low from T2; three TW cycles total; done at cycle 6; rdata=data_in sampled at T3 entry.
- MEM_RD with WAIT_L stuck low, WAIT_TIMEOUT=4 -> four TW cycles, then timeout pulse; no done; strobes high; busy=0 next cycle.
- rst asserted during T2 of MEM_WR -> next cycle all strobes=1, data_oe=0, busy=0, no done; a start in the following cycle is accepted normally.
- start asserted while busy, and in the done cycle -> ignored; a second cycle begins only after start is asserted in IDLE.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared types for the Z80 bus-cycle engines: cycle kinds, bus states and
// default timing parameters.
package z80_pkg;

  typedef enum logic [1:0] {
    MEM_RD = 2'd0,
    MEM_WR = 2'd1,
    IO_RD  = 2'd2,
    IO_WR  = 2'd3
  } cycle_kind_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } bus_state_t;

  localparam int WAIT_TIMEOUT_DEFAULT = 255;
  localparam int IO_AUTO_WAIT_DEFAULT = 1;

  function automatic logic is_io(cycle_kind_t k);
    return (k == IO_RD) || (k == IO_WR);
  endfunction

  function automatic logic is_read(cycle_kind_t k);
    return (k == MEM_RD) || (k == IO_RD);
  endfunction

endpackage

// File: rtl/wait_ctr.sv
// Wait-state bookkeeping for one bus cycle. Auto-waits (I/O only) are served
// first; every WAIT_L=0 sample taken in T2/TW owes one further TW. A separate
// counter of consecutive WAIT_L=0 samples detects a stuck wait line.
module wait_ctr #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,      // cycle accepted: restart all counters
  input  logic auto_load,  // load the auto-wait count on clear (I/O cycles)
  input  logic sample,     // in T2 or TW: WAIT_L is sampled this cycle
  input  logic consume,    // in TW: this cycle serves one pending wait
  input  logic WAIT_L,
  output logic pending,    // at least one more TW is owed after this cycle
  output logic expired     // external wait held too long: abort the cycle
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  logic [1:0]    auto_cnt, auto_nxt;
  logic [2:0]    debt, debt_nxt;
  logic [CW-1:0] cons_cnt;

  // Counter values after this cycle's TW is served and WAIT_L is sampled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    auto_nxt = auto_cnt;
    debt_nxt = debt;
    if (consume) begin
      if (auto_cnt != 2'd0)  auto_nxt = auto_cnt - 2'd1;
      else if (debt != 3'd0) debt_nxt = debt - 3'd1;
    end
    if (sample && !WAIT_L) debt_nxt = debt_nxt + 3'd1;
    pending = (auto_nxt != 2'd0) || (debt_nxt != 3'd0);
    expired = consume && !WAIT_L && (cons_cnt == CW'(WAIT_TIMEOUT));
  end

  // Counter registers: restart on each accepted cycle, advance in T2/TW.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt <= 2'd0;
      debt     <= 3'd0;
      cons_cnt <= '0;
    end else if (clear) begin
      auto_cnt <= auto_load ? 2'(IO_AUTO_WAIT) : 2'd0;
      debt     <= 3'd0;
      cons_cnt <= '0;
    end else if (sample) begin
      auto_cnt <= auto_nxt;
      debt     <= debt_nxt;
      if (WAIT_L)                               cons_cnt <= '0;
      else if (cons_cnt != CW'(WAIT_TIMEOUT))   cons_cnt <= cons_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_io_cycle_fsm.sv
// Bus-cycle engine for Z80 memory/I-O read and write machine cycles.
// Runs T1/T2/TW/T3, honours WAIT_L, aborts on a stuck wait line and returns
// read data captured on entry to T3. All bus outputs decode from registers.
module mem_io_cycle_fsm
  import z80_pkg::*;
#(
  parameter int IO_AUTO_WAIT = IO_AUTO_WAIT_DEFAULT,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  kind,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata_in,
  input  logic [7:0]  data_in,
  input  logic        WAIT_L,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rdata,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L
);

  bus_state_t  state, state_nxt;
  cycle_kind_t kind_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata_q;
  logic        timeout_q;
  logic        accept, pending, expired, in_cycle, late;

  assign accept = (state == IDLE) && start;

  wait_ctr #(
    .IO_AUTO_WAIT(IO_AUTO_WAIT),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .auto_load(is_io(cycle_kind_t'(kind))),
    .sample   ((state == T2) || (state == TW)),
    .consume  (state == TW),
    .WAIT_L   (WAIT_L),
    .pending  (pending),
    .expired  (expired)
  );

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = T1;
      T1:      state_nxt = T2;
      T2:      state_nxt = pending ? TW : T3;
      TW:      state_nxt = expired ? IDLE : (pending ? TW : T3);
      T3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latches, read capture and the abort pulse.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too because rdata, addr_out and
    // data_out are visible on the ports and must read 0 out of reset.
    if (rst) begin
      state     <= IDLE;
      kind_q    <= MEM_RD;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state     <= state_nxt;
      timeout_q <= (state == TW) && expired;
      if (accept) begin
        kind_q  <= cycle_kind_t'(kind);
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
      if ((state_nxt == T3) && (state != T3) && is_read(kind_q))
        rdata_q <= data_in;
    end
  end

  // Moore bus outputs decoded from state and the latched cycle kind.
  always_comb begin
    in_cycle = (state == T1) || (state == T2) || (state == TW) || (state == T3);
    late     = (state == T2) || (state == TW) || (state == T3);
    MREQ_L   = 1'b1;
    IORQ_L   = 1'b1;
    RD_L     = 1'b1;
    WR_L     = 1'b1;
    data_oe  = 1'b0;
    case (kind_q)
      MEM_RD: if (in_cycle) begin MREQ_L = 1'b0; RD_L = 1'b0; end
      MEM_WR: begin
        if (in_cycle) begin MREQ_L = 1'b0; data_oe = 1'b1; end
        if (late) WR_L = 1'b0;
      end
      IO_RD:  if (late) begin IORQ_L = 1'b0; RD_L = 1'b0; end
      IO_WR: begin
        if (in_cycle) data_oe = 1'b1;
        if (late) begin IORQ_L = 1'b0; WR_L = 1'b0; end
      end
      default: ;
    endcase
    busy     = (state != IDLE);
    done     = (state == T3);
    timeout  = timeout_q;
    rdata    = rdata_q;
    addr_out = in_cycle ? addr_q : 16'h0000;
    data_out = data_oe ? wdata_q : 8'h00;
  end

endmodule

// File: tb/tb_mem_io_cycle_fsm.sv
// Directed bench for mem_io_cycle_fsm (IO_AUTO_WAIT=1, WAIT_TIMEOUT=4).
// Expected cycle ends (done/timeout, cycle number, read data) are queued when
// a start is driven and compared by a monitor when the DUT ends the cycle.
module tb_mem_io_cycle_fsm;

  logic        clk, rst, start, WAIT_L;
  logic [1:0]  kind;
  logic [15:0] addr_in, addr_out;
  logic [7:0]  wdata_in, data_in, rdata, data_out;
  logic        busy, done, timeout, data_oe, MREQ_L, IORQ_L, RD_L, WR_L;

  typedef struct {
    bit         to;
    bit         chk_rd;
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   c0;

  mem_io_cycle_fsm #(.IO_AUTO_WAIT(1), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .kind(kind), .addr_in(addr_in),
    .wdata_in(wdata_in), .data_in(data_in), .WAIT_L(WAIT_L), .busy(busy),
    .done(done), .timeout(timeout), .rdata(rdata), .addr_out(addr_out),
    .data_out(data_out), .data_oe(data_oe), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
    .RD_L(RD_L), .WR_L(WR_L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {MREQ_L, IORQ_L, RD_L, WR_L, data_oe}.
  task automatic bus_check(input string tag, input logic [4:0] so,
                           input logic [15:0] a, input logic [7:0] d);
    check({tag, "_strb"}, {27'b0, MREQ_L, IORQ_L, RD_L, WR_L, data_oe}, {27'b0, so});
    check({tag, "_addr"}, {16'b0, addr_out}, {16'b0, a});
    check({tag, "_dout"}, {24'b0, data_out}, {24'b0, d});
  endtask

  task automatic expect_end(input bit to, input bit chk_rd, input logic [7:0] rd, input int c);
    exp_t e;
    e.to = to; e.chk_rd = chk_rd; e.rd = rd; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done/timeout pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 || timeout === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_end", {30'b0, timeout, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("end_kind", {30'b0, timeout, done}, e.to ? 32'd2 : 32'd1);
        check("end_cycle", cyc, e.cyc);
        if (e.chk_rd) check("end_rdata", {24'b0, rdata}, {24'b0, e.rd});
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; kind = 2'd0; addr_in = '0; wdata_in = '0;
    data_in = '0; WAIT_L = 1'b1;
    tick; tick;

    // Reset state
    bus_check("rst", 5'b11110, 16'h0000, 8'h00);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_rdata", 32'(rdata), 0);

    // start together with rst is dropped
    start = 1'b1; addr_in = 16'hDEAD;
    tick;
    check("rst_start_busy", 32'(busy), 0);
    bus_check("rst_start", 5'b11110, 16'h0000, 8'h00);
    rst = 1'b0; start = 1'b0;
    tick;

    // MEM_RD 1234, data A5, no waits
    c0 = cyc; start = 1'b1; kind = 2'd0; addr_in = 16'h1234; data_in = 8'hA5;
    expect_end(0, 1, 8'hA5, c0 + 3);
    tick; start = 1'b0;
    bus_check("mrd_t1", 5'b01010, 16'h1234, 8'h00);
    check("mrd_t1_busy", 32'(busy), 1);
    tick;
    bus_check("mrd_t2", 5'b01010, 16'h1234, 8'h00);
    check("mrd_t2_done", 32'(done), 0);
    tick; data_in = 8'h5A;
    bus_check("mrd_t3", 5'b01010, 16'h1234, 8'h00);
    check("mrd_t3_done", 32'(done), 1);
    check("mrd_t3_rdata", 32'(rdata), 32'hA5);
    tick;
    bus_check("mrd_idle", 5'b11110, 16'h0000, 8'h00);
    check("mrd_idle_busy", 32'(busy), 0);
    check("mrd_idle_rdata", 32'(rdata), 32'hA5);

    // MEM_WR 8000 <- 3C, rdata must stay A5
    c0 = cyc; start = 1'b1; kind = 2'd1; addr_in = 16'h8000; wdata_in = 8'h3C;
    data_in = 8'hFF;
    expect_end(0, 1, 8'hA5, c0 + 3);
    tick; start = 1'b0;
    bus_check("mwr_t1", 5'b01111, 16'h8000, 8'h3C);
    tick;
    bus_check("mwr_t2", 5'b01101, 16'h8000, 8'h3C);
    tick;
    bus_check("mwr_t3", 5'b01101, 16'h8000, 8'h3C);
    check("mwr_t3_done", 32'(done), 1);
    tick;
    bus_check("mwr_idle", 5'b11110, 16'h0000, 8'h00);
    check("mwr_rdata", 32'(rdata), 32'hA5);

    // IO_RD 00FE, one auto wait + WAIT_L low in T2 and first TW
    c0 = cyc; start = 1'b1; kind = 2'd2; addr_in = 16'h00FE; data_in = 8'h11;
    expect_end(0, 1, 8'h77, c0 + 6);
    tick; start = 1'b0; WAIT_L = 1'b0;
    bus_check("iord_t1", 5'b11110, 16'h00FE, 8'h00);
    check("iord_t1_busy", 32'(busy), 1);
    tick;
    bus_check("iord_t2", 5'b10010, 16'h00FE, 8'h00);
    tick;
    bus_check("iord_tw1", 5'b10010, 16'h00FE, 8'h00);
    tick; WAIT_L = 1'b1;
    check("iord_tw2_done", 32'(done), 0);
    tick; data_in = 8'h77;
    check("iord_tw3_done", 32'(done), 0);
    bus_check("iord_tw3", 5'b10010, 16'h00FE, 8'h00);
    tick; data_in = 8'h00;
    check("iord_t3_done", 32'(done), 1);
    check("iord_t3_rdata", 32'(rdata), 32'h77);
    tick;
    check("iord_idle_busy", 32'(busy), 0);

    // IO_WR 0042 <- C3, auto wait only
    c0 = cyc; start = 1'b1; kind = 2'd3; addr_in = 16'h0042; wdata_in = 8'hC3;
    data_in = 8'hEE;
    expect_end(0, 1, 8'h77, c0 + 4);
    tick; start = 1'b0;
    bus_check("iowr_t1", 5'b11111, 16'h0042, 8'hC3);
    tick;
    bus_check("iowr_t2", 5'b10101, 16'h0042, 8'hC3);
    tick;
    bus_check("iowr_tw", 5'b10101, 16'h0042, 8'hC3);
    check("iowr_tw_done", 32'(done), 0);
    tick;
    check("iowr_t3_done", 32'(done), 1);
    tick;

    // MEM_RD with WAIT_L stuck low: four TW then timeout
    c0 = cyc; start = 1'b1; kind = 2'd0; addr_in = 16'h4444;
    expect_end(1, 0, 8'h00, c0 + 7);
    tick; start = 1'b0; WAIT_L = 1'b0;
    tick; tick; tick; tick; tick;
    bus_check("to_tw4", 5'b01010, 16'h4444, 8'h00);
    check("to_tw4_busy", 32'(busy), 1);
    check("to_tw4_timeout", 32'(timeout), 0);
    tick;
    bus_check("to_abort", 5'b11110, 16'h0000, 8'h00);
    check("to_abort_timeout", 32'(timeout), 1);
    check("to_abort_done", 32'(done), 0);
    check("to_abort_busy", 32'(busy), 0);
    check("to_abort_rdata", 32'(rdata), 32'h77);
    WAIT_L = 1'b1;
    tick;
    check("to_after_timeout", 32'(timeout), 0);

    // Reset during T2 of MEM_WR, then a normal start
    start = 1'b1; kind = 2'd1; addr_in = 16'h2222; wdata_in = 8'h99;
    tick; start = 1'b0;
    tick;
    bus_check("rstmid_t2", 5'b01101, 16'h2222, 8'h99);
    rst = 1'b1;
    tick;
    bus_check("rstmid_after", 5'b11110, 16'h0000, 8'h00);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_timeout", 32'(timeout), 0);
    rst = 1'b0;
    c0 = cyc; start = 1'b1; kind = 2'd0; addr_in = 16'h0ABC; data_in = 8'h42;
    expect_end(0, 1, 8'h42, c0 + 3);
    tick; start = 1'b0;
    bus_check("post_rst_t1", 5'b01010, 16'h0ABC, 8'h00);
    tick; tick; tick;

    // start held while busy and in the done cycle is ignored
    c0 = cyc; start = 1'b1; kind = 2'd0; addr_in = 16'h1111; data_in = 8'h5E;
    expect_end(0, 1, 8'h5E, c0 + 3);
    tick; kind = 2'd1; addr_in = 16'hFFFF; wdata_in = 8'h00;
    tick;
    bus_check("busy_ign_t2", 5'b01010, 16'h1111, 8'h00);
    tick;
    check("busy_ign_t3_done", 32'(done), 1);
    bus_check("busy_ign_t3", 5'b01010, 16'h1111, 8'h00);
    tick;
    check("b2b_idle_busy", 32'(busy), 0);
    bus_check("b2b_idle", 5'b11110, 16'h0000, 8'h00);
    c0 = cyc; kind = 2'd1; addr_in = 16'h2468; wdata_in = 8'h81;
    expect_end(0, 1, 8'h5E, c0 + 3);
    tick; start = 1'b0;
    bus_check("b2b_t1", 5'b01111, 16'h2468, 8'h81);
    tick; tick; tick; tick; tick;

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
